mem_stage_hs: RTL and testbench
===============================

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath/memory word width; legal values are 32 and 64.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, meaning maximum cycles waited for a load response before timeout; legal range is 1..255.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports, as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard held instruction.
- in_valid  in  1  EX offers instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  PC_W  instruction PC.
- in_ld  in  1  instruction is a load.
- in_ld_op  in  3  load type: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 lwu, 110 ld, 111 reserved.
- in_rf_we  in  1  register write enable.
- in_rf_waddr  in  5  destination register.
- in_ex_result  in  DATA_W  ALU result or load address.
- dmem_rsp_valid  in  1  data memory response strobe.
- dmem_rdata  in  DATA_W  response word.
- out_valid  out  1  WB bus valid.
- out_ready  in  1  WB accepts.
- out_pc  out  PC_W  instruction PC.
- out_rf_we  out  1  register write enable.
- out_rf_waddr  out  5  destination register.
- out_rf_wdata  out  DATA_W  write data.
- out_misalign  out  1  misaligned or illegal load.
- out_bus_err  out  1  load timed out.
- stall_req  out  1  stage is waiting on memory.

Function
REQ-006 SHALL implement a 3-state FSM: EMPTY, WAIT_RSP, FULL; it holds at most one instruction.
REQ-007 in_ready SHALL be 1 in EMPTY, 1 in FULL when out_ready=1, and 0 otherwise; acceptance occurs when in_valid && in_ready.
REQ-008 On acceptance of a non-load, or of a misaligned/illegal load, the FSM SHALL move to FULL next cycle.
REQ-009 On acceptance of a legal aligned load, the FSM SHALL move to WAIT_RSP and clear the wait counter.
REQ-010 In WAIT_RSP, dmem_rsp_valid=1 SHALL capture the aligned result and move to FULL, giving out_valid the cycle after the response (1-cycle latency).
REQ-011 In WAIT_RSP without a response, the wait counter SHALL increment each cycle.
REQ-012 When the wait counter reaches MAX_WAIT, the FSM SHALL move to FULL with out_bus_err=1, out_rf_we=0 and out_rf_wdata=0.
REQ-013 In FULL, out_valid SHALL be 1; out_valid && out_ready with no new acceptance SHALL move the FSM to EMPTY; with a new acceptance, the FSM SHALL proceed per REQ-008/009 (back-to-back, no bubble).
REQ-014 All out_* SHALL be registered and stable while out_valid=1 && out_ready=0.
REQ-015 Lane index is in_ex_result[log2(DATA_W/8)-1:0]; lb/lbu SHALL select byte lane k, lh/lhu halfword at k, lw/lwu word at k, and ld the full word.
- lb/lh/lw SHALL sign-extend to DATA_W; lbu/lhu/lwu SHALL zero-extend.
REQ-016 Misalignment is lh/lhu with k not a multiple of 2, lw/lwu with k not a multiple of 4, or ld with k≠0.
REQ-017 lwu/ld when DATA_W=32, and op 111, SHALL be illegal.
REQ-018 A misaligned or illegal load SHALL give out_misalign=1, out_rf_we=0, out_rf_wdata=0, and SHALL issue no wait.
REQ-019 A non-load SHALL pass out_rf_wdata = in_ex_result and out_rf_we = in_rf_we.
REQ-020 stall_req SHALL equal (state==WAIT_RSP).
REQ-021 flush SHALL force EMPTY next cycle and suppress acceptance that cycle; flush wins over in_valid, dmem_rsp_valid and timeout.
REQ-022 A flush in WAIT_RSP without a same-cycle response SHALL set drop_pend.
- While drop_pend=1, the next dmem_rsp_valid SHALL be discarded and SHALL clear drop_pend.
- A new load accepted while drop_pend=1 SHALL ignore that discarded response and wait for the following one.
- Timeout SHALL clear drop_pend.
REQ-023 dmem_rsp_valid in EMPTY or FULL with drop_pend=0 SHALL be ignored.

Reset
REQ-024 rst=0 SHALL asynchronously force state EMPTY, drop_pend=0, wait counter=0, out_valid=0, all out_* data/flags=0 and stall_req=0; in_ready SHALL be 1 after reset release.
REQ-025 Reset asserted mid-WAIT_RSP SHALL abandon the load; a later response SHALL be ignored per REQ-023.

Verification
REQ-026 The bench SHALL cover these directed scenarios (DATA_W=32 unless stated):
- lb, addr 0x...01, rsp 0x12AB8034 -> out_rf_wdata 0xFFFFFF80, out_valid 1 cycle after rsp.
- DATA_W=64, lwu, addr 0x...04, rsp 0x89ABCDEF_01234567 -> out_rf_wdata 0x00000000_89ABCDEF; ld at addr 0x...04 -> out_misalign=1, out_rf_we=0.
- lh at addr 0x...03 -> out_misalign=1, no stall_req, FULL next cycle.
- Load with no response, MAX_WAIT=15 -> stall_req high 15 cycles, then out_bus_err=1, out_rf_we=0.
- Load, flush in cycle 2 of WAIT_RSP, new lw accepted, then two responses 0x11111111 then 0x22222222 -> out_rf_wdata 0x22222222.
- out_ready=0 for 3 cycles with FULL -> in_ready=0 and out_* stable; out_ready=1 with in_valid=1 -> back-to-back transfer, no bubble.

Source files
------------

// File: rtl/mem_stage_hs_if.sv
// Handshake bundle between EX, the memory stage, data memory and WB.
interface mem_stage_hs_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic              in_ld;
   logic [2:0]        in_ld_op;
   logic              in_rf_we;
   logic [4:0]        in_rf_waddr;
   logic [DATA_W-1:0] in_ex_result;
   logic              dmem_rsp_valid;
   logic [DATA_W-1:0] dmem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic              out_rf_we;
   logic [4:0]        out_rf_waddr;
   logic [DATA_W-1:0] out_rf_wdata;
   logic              out_misalign;
   logic              out_bus_err;
   logic              stall_req;

   modport slave (
      input  flush, in_valid, in_pc, in_ld, in_ld_op, in_rf_we, in_rf_waddr,
             in_ex_result, dmem_rsp_valid, dmem_rdata, out_ready,
      output in_ready, out_valid, out_pc, out_rf_we, out_rf_waddr,
             out_rf_wdata, out_misalign, out_bus_err, stall_req
   );

   modport master (
      output flush, in_valid, in_pc, in_ld, in_ld_op, in_rf_we, in_rf_waddr,
             in_ex_result, dmem_rsp_valid, dmem_rdata, out_ready,
      input  in_ready, out_valid, out_pc, out_rf_we, out_rf_waddr,
             out_rf_wdata, out_misalign, out_bus_err, stall_req
   );
endinterface

// File: rtl/mem_stage_hs.sv
// Single-entry memory stage: holds one instruction, waits for load data,
// aligns/extends it, and reports misaligned/illegal loads and timeouts.
module mem_stage_hs #(
   parameter int DATA_W   = 32,
   parameter int PC_W     = 32,
   parameter int MAX_WAIT = 15
) (
   input logic           clk,
   input logic           rst,
   mem_stage_hs_if.slave bus
);
   localparam int LANE_W = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {EMPTY, WAIT_RSP, FULL} state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                drop_pend_q, drop_pend_d;
   logic [2:0]          op_q;
   logic [LANE_W-1:0]   lane_q;
   logic [PC_W-1:0]     out_pc_q;
   logic                out_rf_we_q;
   logic [4:0]          out_rf_waddr_q;
   logic [DATA_W-1:0]   out_rf_wdata_q;
   logic                out_misalign_q;
   logic                out_bus_err_q;

   logic                in_ready;
   logic                accept;
   logic                ld_bad;
   logic                rsp_hit;
   logic                timeout;
   logic [LANE_W-1:0]   lane_in;
   logic [DATA_W-1:0]   sh;
   logic [DATA_W-1:0]   ld_data;

   assign lane_in = bus.in_ex_result[LANE_W-1:0];
   assign accept  = bus.in_valid && in_ready && !bus.flush;
   // A response while drop_pend is set belongs to a flushed load and is eaten.
   assign rsp_hit = (state_q == WAIT_RSP) && bus.dmem_rsp_valid && !drop_pend_q;
   assign timeout = (state_q == WAIT_RSP) && !rsp_hit && (cnt_q == 8'(MAX_WAIT - 1));

   // Decode misaligned or illegal load types from the incoming address lane.
   always_comb begin
      ld_bad = 1'b0;
      case (bus.in_ld_op)
         3'b010, 3'b011: ld_bad = lane_in[0];
         3'b100:         ld_bad = (lane_in[1:0] != 2'b00);
         3'b101:         ld_bad = (DATA_W == 32) || (lane_in[1:0] != 2'b00);
         3'b110:         ld_bad = (DATA_W == 32) || (lane_in != '0);
         3'b111:         ld_bad = 1'b1;
         default:        ld_bad = 1'b0;
      endcase
   end

   // Shift the response down to the addressed lane and sign/zero extend.
   always_comb begin
      sh = bus.dmem_rdata >> {lane_q, 3'b000};
      case (op_q)
         3'b000:  ld_data = DATA_W'($signed(sh[7:0]));
         3'b001:  ld_data = DATA_W'(sh[7:0]);
         3'b010:  ld_data = DATA_W'($signed(sh[15:0]));
         3'b011:  ld_data = DATA_W'(sh[15:0]);
         3'b100:  ld_data = DATA_W'($signed(sh[31:0]));
         3'b101:  ld_data = DATA_W'(sh[31:0]);
         default: ld_data = sh;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= EMPTY;
      else      state_q <= state_d;
   end

   // FSM next-state logic; flush overrides everything else.
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) state_d = (bus.in_ld && !ld_bad) ? WAIT_RSP : FULL;
            end
            WAIT_RSP: begin
               if (rsp_hit || timeout) state_d = FULL;
            end
            FULL: begin
               if (accept)             state_d = (bus.in_ld && !ld_bad) ? WAIT_RSP : FULL;
               else if (bus.out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // FSM outputs: handshake and stall.
   always_comb begin
      in_ready      = (state_q == EMPTY) || ((state_q == FULL) && bus.out_ready);
      bus.in_ready  = in_ready;
      bus.out_valid = (state_q == FULL);
      bus.stall_req = (state_q == WAIT_RSP);
   end

   // Wait counter and pending-discard flag next values.
   // drop_pend stays set if a flush hits while an older discarded response
   // is still outstanding, since the flushed load's own response is then due.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.flush || accept)        cnt_d = '0;
      else if (state_q == WAIT_RSP && !rsp_hit) cnt_d = cnt_q + 8'd1;

      drop_pend_d = drop_pend_q;
      if (bus.dmem_rsp_valid && drop_pend_q)    drop_pend_d = 1'b0;
      if (timeout && !bus.flush)                drop_pend_d = 1'b0;
      if (bus.flush && state_q == WAIT_RSP && !rsp_hit) drop_pend_d = 1'b1;
   end

   // Counter and discard-flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         drop_pend_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         drop_pend_q <= drop_pend_d;
      end
   end

   // Output payload registers: loaded on acceptance, completed on response/timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_pc_q       <= '0;
         out_rf_we_q    <= 1'b0;
         out_rf_waddr_q <= '0;
         out_rf_wdata_q <= '0;
         out_misalign_q <= 1'b0;
         out_bus_err_q  <= 1'b0;
         op_q           <= '0;
         lane_q         <= '0;
      end else if (!bus.flush) begin
         if (accept) begin
            out_pc_q       <= bus.in_pc;
            out_rf_waddr_q <= bus.in_rf_waddr;
            out_bus_err_q  <= 1'b0;
            op_q           <= bus.in_ld_op;
            lane_q         <= lane_in;
            if (!bus.in_ld) begin
               out_rf_we_q    <= bus.in_rf_we;
               out_rf_wdata_q <= bus.in_ex_result;
               out_misalign_q <= 1'b0;
            end else if (ld_bad) begin
               out_rf_we_q    <= 1'b0;
               out_rf_wdata_q <= '0;
               out_misalign_q <= 1'b1;
            end else begin
               out_rf_we_q    <= bus.in_rf_we;
               out_rf_wdata_q <= '0;
               out_misalign_q <= 1'b0;
            end
         end else if (rsp_hit) begin
            out_rf_wdata_q <= ld_data;
         end else if (timeout) begin
            out_rf_we_q    <= 1'b0;
            out_rf_wdata_q <= '0;
            out_bus_err_q  <= 1'b1;
         end
      end
   end

   assign bus.out_pc       = out_pc_q;
   assign bus.out_rf_we    = out_rf_we_q;
   assign bus.out_rf_waddr = out_rf_waddr_q;
   assign bus.out_rf_wdata = out_rf_wdata_q;
   assign bus.out_misalign = out_misalign_q;
   assign bus.out_bus_err  = out_bus_err_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: 32-bit and 64-bit instances.
module tb_mem_stage_hs;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage_hs_if #(.DATA_W(32), .PC_W(32)) a ();
   mem_stage_hs_if #(.DATA_W(64), .PC_W(32)) b ();

   mem_stage_hs #(.DATA_W(32), .PC_W(32), .MAX_WAIT(15)) u32 (.clk(clk), .rst(rst), .bus(a));
   mem_stage_hs #(.DATA_W(64), .PC_W(32), .MAX_WAIT(15)) u64 (.clk(clk), .rst(rst), .bus(b));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer32(input logic ld, input logic [2:0] op, input logic [31:0] ex,
                          input logic [31:0] pc);
      a.in_valid = 1'b1; a.in_ld = ld; a.in_ld_op = op; a.in_ex_result = ex;
      a.in_pc = pc; a.in_rf_we = 1'b1; a.in_rf_waddr = 5'd7;
   endtask

   task automatic run_ld32(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rsp, input logic [31:0] exp, input logic mis);
      a.out_ready = 1'b1;
      offer32(1'b1, op, addr, 32'h0000_0400);
      tick();
      a.in_valid = 1'b0;
      if (!mis) begin
         check({tag, ".stall"}, a.stall_req, 1);
         check({tag, ".vwait"}, a.out_valid, 0);
         a.dmem_rsp_valid = 1'b1; a.dmem_rdata = rsp;
         tick();
         a.dmem_rsp_valid = 1'b0;
      end else begin
         check({tag, ".nostall"}, a.stall_req, 0);
      end
      check({tag, ".valid"}, a.out_valid, 1);
      check({tag, ".data"},  a.out_rf_wdata, exp);
      check({tag, ".mis"},   a.out_misalign, mis);
      check({tag, ".we"},    a.out_rf_we, !mis);
      tick();
      check({tag, ".drain"}, a.out_valid, 0);
   endtask

   task automatic run_ld64(input string tag, input logic [2:0] op, input logic [63:0] addr,
                           input logic [63:0] rsp, input logic [63:0] exp, input logic mis);
      b.out_ready = 1'b1;
      b.in_valid = 1'b1; b.in_ld = 1'b1; b.in_ld_op = op; b.in_ex_result = addr;
      b.in_pc = 32'h0000_0800; b.in_rf_we = 1'b1; b.in_rf_waddr = 5'd9;
      tick();
      b.in_valid = 1'b0;
      if (!mis) begin
         check({tag, ".stall"}, b.stall_req, 1);
         b.dmem_rsp_valid = 1'b1; b.dmem_rdata = rsp;
         tick();
         b.dmem_rsp_valid = 1'b0;
      end else begin
         check({tag, ".nostall"}, b.stall_req, 0);
      end
      check({tag, ".valid"}, b.out_valid, 1);
      check({tag, ".data"},  b.out_rf_wdata, exp);
      check({tag, ".mis"},   b.out_misalign, mis);
      check({tag, ".we"},    b.out_rf_we, !mis);
      tick();
      check({tag, ".drain"}, b.out_valid, 0);
   endtask

   initial begin
      int n;
      {a.flush, a.in_valid, a.in_pc, a.in_ld, a.in_ld_op, a.in_rf_we, a.in_rf_waddr,
       a.in_ex_result, a.dmem_rsp_valid, a.dmem_rdata} = '0;
      {b.flush, b.in_valid, b.in_pc, b.in_ld, b.in_ld_op, b.in_rf_we, b.in_rf_waddr,
       b.in_ex_result, b.dmem_rsp_valid, b.dmem_rdata} = '0;
      a.out_ready = 1'b1;
      b.out_ready = 1'b1;

      // Reset state
      tick(); tick();
      check("rst.valid", a.out_valid, 0);
      check("rst.stall", a.stall_req, 0);
      check("rst.wdata", a.out_rf_wdata, 0);
      check("rst.pc",    a.out_pc, 0);
      check("rst.flags", {a.out_misalign, a.out_bus_err, a.out_rf_we}, 0);
      rst = 1'b1;
      #1;
      check("rst.ready", a.in_ready, 1);

      // Load alignment / extension, 32-bit datapath
      run_ld32("lb1",   3'b000, 32'h1000_0001, 32'h12AB_8034, 32'hFFFF_FF80, 1'b0);
      run_ld32("lbu1",  3'b001, 32'h1000_0001, 32'h12AB_8034, 32'h0000_0080, 1'b0);
      run_ld32("lb2",   3'b000, 32'h1000_0002, 32'h12AB_8034, 32'hFFFF_FFAB, 1'b0);
      run_ld32("lbu3",  3'b001, 32'h1000_0003, 32'h12AB_8034, 32'h0000_0012, 1'b0);
      run_ld32("lh0",   3'b010, 32'h1000_0000, 32'h12AB_8034, 32'hFFFF_8034, 1'b0);
      run_ld32("lhu2",  3'b011, 32'h1000_0002, 32'h12AB_8034, 32'h0000_12AB, 1'b0);
      run_ld32("lw0",   3'b100, 32'h1000_0000, 32'h12AB_8034, 32'h12AB_8034, 1'b0);
      run_ld32("lh3",   3'b010, 32'h1000_0003, 32'h0,         32'h0,         1'b1);
      run_ld32("lw2",   3'b100, 32'h1000_0002, 32'h0,         32'h0,         1'b1);
      run_ld32("lwu32", 3'b101, 32'h1000_0000, 32'h0,         32'h0,         1'b1);
      run_ld32("ld32",  3'b110, 32'h1000_0000, 32'h0,         32'h0,         1'b1);
      run_ld32("op7",   3'b111, 32'h1000_0000, 32'h0,         32'h0,         1'b1);

      // 64-bit datapath
      run_ld64("lwu4", 3'b101, 64'h4, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_89AB_CDEF, 1'b0);
      run_ld64("lw4",  3'b100, 64'h4, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
      run_ld64("ld0",  3'b110, 64'h0, 64'h89AB_CDEF_0123_4567, 64'h89AB_CDEF_0123_4567, 1'b0);
      run_ld64("lh6",  3'b010, 64'h6, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_FFFF_89AB, 1'b0);
      run_ld64("lbu5", 3'b001, 64'h5, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_0000_00CD, 1'b0);
      run_ld64("ld4",  3'b110, 64'h4, 64'h0, 64'h0, 1'b1);

      // Non-load passthrough
      offer32(1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0000_0050);
      tick();
      a.in_valid = 1'b0;
      check("alu.valid", a.out_valid, 1);
      check("alu.data",  a.out_rf_wdata, 32'hDEAD_BEEF);
      check("alu.we",    a.out_rf_we, 1);
      check("alu.pc",    a.out_pc, 32'h0000_0050);
      tick();

      // Timeout
      offer32(1'b1, 3'b100, 32'h1000_0000, 32'h0000_0060);
      tick();
      a.in_valid = 1'b0;
      n = 0;
      while (a.stall_req && n < 40) begin
         n++;
         tick();
      end
      check("to.cycles", 64'(n), 15);
      check("to.valid",  a.out_valid, 1);
      check("to.berr",   a.out_bus_err, 1);
      check("to.we",     a.out_rf_we, 0);
      check("to.data",   a.out_rf_wdata, 0);
      tick();

      // Flush in WAIT_RSP, then a new load must skip the stale response
      offer32(1'b1, 3'b100, 32'h1000_0000, 32'h0000_0100);
      tick();
      a.in_valid = 1'b0;
      tick();
      a.flush = 1'b1;
      tick();
      a.flush = 1'b0;
      check("fl.stall", a.stall_req, 0);
      check("fl.valid", a.out_valid, 0);
      offer32(1'b1, 3'b100, 32'h1000_0000, 32'h0000_0200);
      tick();
      a.in_valid = 1'b0;
      a.dmem_rsp_valid = 1'b1; a.dmem_rdata = 32'h1111_1111;
      tick();
      check("fl.skip", {a.stall_req, a.out_valid}, 2'b10);
      a.dmem_rdata = 32'h2222_2222;
      tick();
      a.dmem_rsp_valid = 1'b0;
      check("fl.valid2", a.out_valid, 1);
      check("fl.data",   a.out_rf_wdata, 32'h2222_2222);
      check("fl.pc",     a.out_pc, 32'h0000_0200);
      tick();

      // Stray response in EMPTY is ignored
      a.dmem_rsp_valid = 1'b1; a.dmem_rdata = 32'hFFFF_FFFF;
      tick();
      a.dmem_rsp_valid = 1'b0;
      check("stray.valid", a.out_valid, 0);
      offer32(1'b1, 3'b100, 32'h1000_0000, 32'h0000_0210);
      tick();
      a.in_valid = 1'b0;
      tick();
      check("stray.wait", a.stall_req, 1);
      a.dmem_rsp_valid = 1'b1; a.dmem_rdata = 32'h0BAD_F00D;
      tick();
      a.dmem_rsp_valid = 1'b0;
      check("stray.data", a.out_rf_wdata, 32'h0BAD_F00D);
      tick();

      // Backpressure then back-to-back transfer
      offer32(1'b0, 3'b000, 32'hA5A5_A5A5, 32'h0000_0300);
      tick();
      a.out_ready = 1'b0;
      offer32(1'b0, 3'b000, 32'h5A5A_5A5A, 32'h0000_0304);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp.ready", a.in_ready, 0);
         check("bp.valid", a.out_valid, 1);
         check("bp.pc",    a.out_pc, 32'h0000_0300);
         check("bp.data",  a.out_rf_wdata, 32'hA5A5_A5A5);
         tick();
      end
      a.out_ready = 1'b1;
      #1;
      check("b2b.ready", a.in_ready, 1);
      tick();
      a.in_valid = 1'b0;
      check("b2b.valid", a.out_valid, 1);
      check("b2b.pc",    a.out_pc, 32'h0000_0304);
      check("b2b.data",  a.out_rf_wdata, 32'h5A5A_5A5A);
      tick();
      check("b2b.empty", a.out_valid, 0);

      // Reset mid-wait abandons the load; its response is ignored
      offer32(1'b1, 3'b100, 32'h1000_0000, 32'h0000_0500);
      tick();
      a.in_valid = 1'b0;
      check("rw.stall", a.stall_req, 1);
      rst = 1'b0;
      #1;
      check("rw.async", a.stall_req, 0);
      tick();
      rst = 1'b1;
      a.dmem_rsp_valid = 1'b1; a.dmem_rdata = 32'h7777_7777;
      tick();
      a.dmem_rsp_valid = 1'b0;
      check("rw.ignore", {a.out_valid, a.stall_req}, 0);
      check("rw.data",   a.out_rf_wdata, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
